piso_tx: RTL

- Parallel-in/serial-out transmitter that serialises one WIDTH-bit word per frame onto a single-bit line.
- Framing is marked by sframe; an optional even-parity bit can follow the data.
- It drives the serial side of a point-to-point link whose far end is a sampling serial receiver built from D flip-flops.
- Upstream logic hands words in through a valid/ready handshake.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_timer.sv | 30 +++
 rtl/piso_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY
  } tx_state_t;

  // Bits needed to hold values 0..n inclusive; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period timer: o_tick marks the final clk cycle of each serial bit.
module piso_bit_timer
  import piso_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = cnt_width(BIT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  // With BIT_CYCLES=1 the terminal count is zero, so r_cnt stays constant.
  assign w_tc   = (r_cnt == CW'(BIT_CYCLES - 1));
  assign o_tick = i_en && w_tc;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load, sframe framing
// and an optional trailing even-parity bit. All outputs are registered.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  // state     | meaning
  // ST_IDLE   | line low, load_ready high, waiting for a word
  // ST_SHIFT  | data bits on sout, one per bit period
  // ST_PARITY | even-parity bit on sout for one bit period

  localparam int BW = cnt_width(WIDTH);

  tx_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shifted;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_par;
  logic             r_sout, r_sframe, r_ready, r_done;
  logic             w_sout_nxt, w_sframe_nxt, w_ready_nxt, w_done_nxt;
  logic             w_accept, w_tick, w_last_data, w_frame_end, w_timer_clr;
  logic             w_din_head, w_sh_head;

  assign w_accept    = (r_state == ST_IDLE) && r_ready && load_valid;
  assign w_last_data = (r_state == ST_SHIFT) && w_tick && (r_bit_cnt == BW'(WIDTH - 1));
  assign w_frame_end = (PARITY_EN != 0) ? ((r_state == ST_PARITY) && w_tick) : w_last_data;
  assign w_timer_clr = rst || w_accept || w_frame_end;

  assign w_shifted  = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_din_head = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign w_sh_head  = (MSB_FIRST != 0) ? r_shreg[WIDTH-2] : r_shreg[1];

  piso_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk    (clk),
    .i_clr  (w_timer_clr),
    .i_en   (r_state != ST_IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (w_last_data) w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_IDLE;
      ST_PARITY: if (w_tick) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    w_sout_nxt   = r_sout;
    w_sframe_nxt = r_sframe;
    w_ready_nxt  = r_ready;
    w_done_nxt   = 1'b0;
    if (w_accept) begin
      w_sout_nxt   = w_din_head;
      w_sframe_nxt = 1'b1;
      w_ready_nxt  = 1'b0;
    end else if (w_frame_end) begin
      w_sout_nxt   = 1'b0;
      w_sframe_nxt = 1'b0;
      w_ready_nxt  = 1'b1;
      w_done_nxt   = 1'b1;
    end else if (w_last_data) begin
      w_sout_nxt   = r_par;
    end else if ((r_state == ST_SHIFT) && w_tick) begin
      w_sout_nxt   = w_sh_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sout   <= 1'b0;
      r_sframe <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_sout   <= w_sout_nxt;
      r_sframe <= w_sframe_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else if (w_accept) begin
      r_shreg   <= din;
      r_bit_cnt <= '0;
      r_par     <= ^din;
    end else if ((r_state == ST_SHIFT) && w_tick) begin
      r_shreg   <= w_shifted;
      r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + BW'(1);
    end
  end

  assign load_ready = r_ready;
  assign sout       = r_sout;
  assign sframe     = r_sframe;
  assign done       = r_done;

endmodule
